// File: rtl/result_buf_pkg.sv
// Shared types and defaults for the result buffer slot allocator.
package result_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_t;

    localparam int unsigned DEFAULT_SLOT_STRIDE = 1550;

endpackage

// File: rtl/slot_pointer.sv
// Wrapping slot index plus its incrementally computed base address.
module slot_pointer
    import result_buf_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = 5,
    parameter int unsigned SLOT_STRIDE = DEFAULT_SLOT_STRIDE,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    localparam int unsigned IW = $clog2(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear_i,
    input  logic                  advance_i,
    output logic [IW-1:0]         idx_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    localparam longint unsigned LAST_ADDR =
        longint'(BASE_ADDR) +
        longint'(NUM_SLOTS - 1) * longint'(SLOT_STRIDE);

    if (NUM_SLOTS < 2) begin : g_chk_n
        $fatal(1, "slot_pointer: NUM_SLOTS must be >= 2");
    end
    if (LAST_ADDR >= (64'd1 << ADDR_WIDTH)) begin : g_chk_addr
        $fatal(1, "slot_pointer: last slot address exceeds ADDR_WIDTH");
    end

    logic [IW-1:0]         idx_q,  idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_comb begin
        idx_d  = idx_q;
        addr_d = addr_q;
        if (clear_i) begin
            idx_d  = '0;
            addr_d = BASE_ADDR;
        end else if (advance_i) begin
            if (idx_q == IW'(NUM_SLOTS - 1)) begin
                idx_d  = '0;
                addr_d = BASE_ADDR;
            end else begin
                idx_d  = idx_q + 1'b1;
                addr_d = addr_q + ADDR_WIDTH'(SLOT_STRIDE);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx_q  <= '0;
            addr_q <= BASE_ADDR;
        end else begin
            idx_q  <= idx_d;
            addr_q <= addr_d;
        end
    end

    assign idx_o  = idx_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/result_slot_allocator.sv
// Circular result-slot allocator: write/read pointers, occupancy FSM,
// fill count and sticky overflow flag.
module result_slot_allocator
    import result_buf_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = 5,
    parameter int unsigned SLOT_STRIDE = DEFAULT_SLOT_STRIDE,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    localparam int unsigned CW = $clog2(NUM_SLOTS + 1),
    localparam int unsigned IW = $clog2(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear_i,
    input  logic                  inc_addr_i,
    input  logic                  release_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic                  wr_valid_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_valid_o,
    output logic [CW-1:0]         count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  overflow_o,
    output logic [IW-1:0]         wr_idx_o,
    output logic [IW-1:0]         rd_idx_o
);

    occ_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q,   ovf_d;
    logic          commit_ok;
    logic          release_ok;

    // Acceptance is judged on the pre-edge count only.
    assign commit_ok  = inc_addr_i && (count_q < CW'(NUM_SLOTS));
    assign release_ok = release_i && (count_q != '0);

    slot_pointer #(
        .NUM_SLOTS  (NUM_SLOTS),
        .SLOT_STRIDE(SLOT_STRIDE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_wr_ptr (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear_i  (clear_i),
        .advance_i(commit_ok),
        .idx_o    (wr_idx_o),
        .addr_o   (wr_addr_o)
    );

    slot_pointer #(
        .NUM_SLOTS  (NUM_SLOTS),
        .SLOT_STRIDE(SLOT_STRIDE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_rd_ptr (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear_i  (clear_i),
        .advance_i(release_ok),
        .idx_o    (rd_idx_o),
        .addr_o   (rd_addr_o)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            state_d = EMPTY;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (inc_addr_i && !commit_ok) begin
                ovf_d = 1'b1;
            end
            if (commit_ok && !release_ok) begin
                count_d = count_q + 1'b1;
            end else if (release_ok && !commit_ok) begin
                count_d = count_q - 1'b1;
            end
            unique case (state_q)
                EMPTY: begin
                    if (commit_ok) state_d = PARTIAL;
                end
                PARTIAL: begin
                    if (commit_ok && !release_ok &&
                        count_q == CW'(NUM_SLOTS - 1)) begin
                        state_d = FULL;
                    end else if (release_ok && !commit_ok &&
                                 count_q == CW'(1)) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (release_ok) state_d = PARTIAL;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= EMPTY;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign full_o     = (state_q == FULL);
    assign empty_o    = (state_q == EMPTY);
    assign wr_valid_o = ~full_o;
    assign rd_valid_o = ~empty_o;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_result_slot_allocator.sv
// Directed self-checking bench for result_slot_allocator at default params.
module tb_result_slot_allocator;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        clear_i = 1'b0;
    logic        inc_addr_i = 1'b0;
    logic        release_i = 1'b0;
    logic [31:0] wr_addr_o;
    logic        wr_valid_o;
    logic [31:0] rd_addr_o;
    logic        rd_valid_o;
    logic [2:0]  count_o;
    logic        full_o;
    logic        empty_o;
    logic        overflow_o;
    logic [2:0]  wr_idx_o;
    logic [2:0]  rd_idx_o;

    int n_asserts = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    result_slot_allocator dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear_i   (clear_i),
        .inc_addr_i(inc_addr_i),
        .release_i (release_i),
        .wr_addr_o (wr_addr_o),
        .wr_valid_o(wr_valid_o),
        .rd_addr_o (rd_addr_o),
        .rd_valid_o(rd_valid_o),
        .count_o   (count_o),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .overflow_o(overflow_o),
        .wr_idx_o  (wr_idx_o),
        .rd_idx_o  (rd_idx_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic inc, input logic rel, input logic clr);
        inc_addr_i = inc;
        release_i  = rel;
        clear_i    = clr;
        @(posedge clk);
        #1;
        inc_addr_i = 1'b0;
        release_i  = 1'b0;
        clear_i    = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".wr_addr"},  wr_addr_o,  32'h0);
        chk({tag, ".rd_addr"},  rd_addr_o,  32'h0);
        chk({tag, ".count"},    count_o,    32'd0);
        chk({tag, ".empty"},    empty_o,    32'd1);
        chk({tag, ".full"},     full_o,     32'd0);
        chk({tag, ".wr_valid"}, wr_valid_o, 32'd1);
        chk({tag, ".rd_valid"}, rd_valid_o, 32'd0);
        chk({tag, ".overflow"}, overflow_o, 32'd0);
    endtask

    logic [31:0] exp_wr [5];
    logic [31:0] exp_rd [5];

    initial begin
        exp_wr = '{32'h60E, 32'hC1C, 32'h122A, 32'h1838, 32'h0};
        exp_rd = '{32'h60E, 32'hC1C, 32'h122A, 32'h1838, 32'h0};

        // 1: reset and idle
        #12;
        chk_reset_vals("rst_low");
        @(negedge clk);
        n_rst = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk_reset_vals("idle");

        // 2: fill with five commits
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0);
            chk($sformatf("fill%0d.wr_addr", i), wr_addr_o, exp_wr[i]);
            chk($sformatf("fill%0d.count", i), count_o, 32'(i + 1));
        end
        chk("fill.full", full_o, 32'd1);
        chk("fill.wr_valid", wr_valid_o, 32'd0);
        chk("fill.rd_valid", rd_valid_o, 32'd1);
        chk("fill.empty", empty_o, 32'd0);
        chk("fill.rd_addr", rd_addr_o, 32'h0);

        // 3: commit while full, then drain
        cyc(1, 0, 0);
        chk("ovf.wr_addr", wr_addr_o, 32'h0);
        chk("ovf.count", count_o, 32'd5);
        chk("ovf.overflow", overflow_o, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0);
            chk($sformatf("drain%0d.rd_addr", i), rd_addr_o, exp_rd[i]);
            chk($sformatf("drain%0d.count", i), count_o, 32'(4 - i));
        end
        chk("drain.overflow", overflow_o, 32'd1);
        chk("drain.empty", empty_o, 32'd1);
        chk("drain.rd_valid", rd_valid_o, 32'd0);

        // 4: simultaneous commit and release at count 2
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("two.wr_addr", wr_addr_o, 32'hC1C);
        chk("two.count", count_o, 32'd2);
        cyc(1, 1, 0);
        chk("both.count", count_o, 32'd2);
        chk("both.rd_addr", rd_addr_o, 32'h60E);
        chk("both.wr_addr", wr_addr_o, 32'h122A);
        chk("both.empty", empty_o, 32'd0);

        // clear restores reset values including overflow
        cyc(0, 0, 1);
        chk_reset_vals("clear1");

        // 5: release while empty, then commit+release while full
        cyc(0, 1, 0);
        chk_reset_vals("rel_empty");
        for (int i = 0; i < 5; i++) cyc(1, 0, 0);
        chk("refill.full", full_o, 32'd1);
        cyc(1, 1, 0);
        chk("fullboth.count", count_o, 32'd4);
        chk("fullboth.overflow", overflow_o, 32'd1);
        chk("fullboth.rd_addr", rd_addr_o, 32'h60E);
        chk("fullboth.wr_addr", wr_addr_o, 32'h0);
        chk("fullboth.full", full_o, 32'd0);
        chk("fullboth.wr_valid", wr_valid_o, 32'd1);

        // 6: async reset at count 3 with overflow set
        cyc(0, 1, 0);
        chk("pre_rst.count", count_o, 32'd3);
        chk("pre_rst.rd_addr", rd_addr_o, 32'hC1C);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        n_rst = 1'b1;
        cyc(0, 0, 0);
        chk_reset_vals("post_rst");

        // rebuild count 3 with overflow, then clear (clear beats a commit)
        for (int i = 0; i < 6; i++) cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        chk("pre_clr.count", count_o, 32'd3);
        chk("pre_clr.overflow", overflow_o, 32'd1);
        cyc(1, 0, 1);
        chk_reset_vals("clear2");
        cyc(1, 0, 0);
        chk("after_clr.wr_addr", wr_addr_o, 32'h60E);
        chk("after_clr.count", count_o, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
